fm_phase_gen: RTL and testbench

FM_PHASE_GEN -- requirements
Module: fm_phase_gen

---
 rtl/fm_pkg.sv | 27 ++
 rtl/fm_phase_ram.sv | 24 ++
 rtl/fm_phase_gen.sv | 126 ++++++++++++
 tb/tb_fm_phase_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// Shared types and constants for the FM operator phase generator.
package fm_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } fm_state_e;

  localparam int unsigned LFSR_W     = 23;
  localparam int unsigned LFSR_TAP_A = 22;
  localparam int unsigned LFSR_TAP_B = 17;
  localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1);

  localparam int unsigned VCNT_W = 13;

  // MULT code to frequency multiplier (x2 scale, so code 0 means 0.5 -> 1).
  function automatic logic [4:0] mult_factor(input logic [3:0] code);
    logic [4:0] m;
    if (code == 4'd0)        m = 5'd1;
    else if (code <= 4'd10)  m = {code, 1'b0};
    else if (code == 4'd11)  m = 5'd20;
    else if (code <= 4'd13)  m = 5'd24;
    else                     m = 5'd30;
    return m;
  endfunction

endpackage

// File: rtl/fm_phase_ram.sv
// Per-operator phase accumulator storage: synchronous write, combinational read.
module fm_phase_ram #(
  parameter int DEPTH = 36,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/fm_phase_gen.sv
// Time-multiplexed FM operator phase generator with vibrato, hard sync,
// phase modulation offset and a rhythm noise LFSR.
module fm_phase_gen
  import fm_pkg::*;
#(
  parameter int NUM_OPS = 36,
  parameter int ACC_W   = 19,
  parameter int PHASE_W = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(NUM_OPS)-1:0] op_sel,
  input  logic                       next,
  input  logic                       restart,
  input  logic [2:0]                 block,
  input  logic [9:0]                 fnum,
  input  logic [3:0]                 mult,
  input  logic                       vib,
  input  logic                       dvb,
  input  logic                       sync_en,
  input  logic [PHASE_W-1:0]         pm_offset,
  output logic                       ready,
  output logic [PHASE_W-1:0]         phase,
  output logic                       phase_valid,
  output logic                       wrap,
  output logic                       noise
);

  localparam int OP_W = $clog2(NUM_OPS);

  fm_state_e         state_q, state_d;
  logic [OP_W-1:0]   clr_idx_q, clr_idx_d;
  logic [VCNT_W-1:0] vcnt_q;
  logic [LFSR_W-1:0] lfsr_q;

  logic              clearing, accept, frame_end;
  logic [ACC_W-1:0]  rd_data, base, inc, vib_term, new_acc;
  logic [ACC_W+1:0]  sum;
  logic [15:0]       fw;
  logic [20:0]       scaled;
  logic [2:0]        vib_delta;

  logic              ram_we;
  logic [OP_W-1:0]   ram_waddr;
  logic [ACC_W-1:0]  ram_wdata;

  assign clearing  = (state_q == ST_CLEAR);
  assign accept    = next && (state_q == ST_RUN) &&
                     ({1'b0, op_sel} < (OP_W+1)'(NUM_OPS));
  assign frame_end = accept && (op_sel == OP_W'(NUM_OPS - 1));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      if (clr_idx_q == OP_W'(NUM_OPS - 1)) begin
        state_d   = ST_RUN;
        clr_idx_d = '0;
      end else begin
        clr_idx_d = clr_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    fw     = 16'(fnum) << block;
    scaled = 21'(fw) * 21'(mult_factor(mult));
    inc    = ACC_W'(scaled >> 2);

    vib_delta = fnum[9:7];
    if (vcnt_q[11:10] == 2'b11) vib_delta = vib_delta >> 1;
    if (!dvb)                   vib_delta = vib_delta >> 1;
    vib_term = '0;
    if (vib) vib_term = vcnt_q[VCNT_W-1] ? ~ACC_W'(vib_delta) : ACC_W'(vib_delta);

    // The wrap register doubles as the latched carry of the previous accepted step.
    base    = (restart || (sync_en && wrap)) ? '0 : rd_data;
    sum     = (ACC_W+2)'(base) + (ACC_W+2)'(inc) + (ACC_W+2)'(vib_term);
    new_acc = sum[ACC_W-1:0];
  end

  assign ram_we    = clearing || accept;
  assign ram_waddr = clearing ? clr_idx_q : op_sel;
  assign ram_wdata = clearing ? '0 : new_acc;

  fm_phase_ram #(
    .DEPTH (NUM_OPS),
    .WIDTH (ACC_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (op_sel),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_idx_q   <= '0;
      ready       <= 1'b0;
      phase       <= '0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
      vcnt_q      <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      ready       <= (state_q == ST_RUN);
      phase_valid <= accept;
      if (accept) begin
        phase <= new_acc[ACC_W-1 -: PHASE_W] + pm_offset;
        wrap  <= |sum[ACC_W+1:ACC_W];
      end
      if (frame_end) begin
        vcnt_q <= vcnt_q + 1'b1;
        lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
      end
    end
  end

  assign noise = lfsr_q[LFSR_W-1];

endmodule

// File: tb/tb_fm_phase_gen.sv
// Directed bench for fm_phase_gen with hand-computed accumulator/phase values.
module tb_fm_phase_gen;

  localparam int NUM_OPS = 36;
  localparam int ACC_W   = 19;
  localparam int PHASE_W = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic [5:0]         op_sel;
  logic               next, restart;
  logic [2:0]         block;
  logic [9:0]         fnum;
  logic [3:0]         mult;
  logic               vib, dvb, sync_en;
  logic [PHASE_W-1:0] pm_offset;
  logic               ready;
  logic [PHASE_W-1:0] phase;
  logic               phase_valid, wrap, noise;

  int n_checks = 0;
  int n_pass   = 0;
  logic [22:0] lfsr_m;
  int exp_seq[4] = '{0, 1, 1, 2};

  fm_phase_gen #(
    .NUM_OPS (NUM_OPS),
    .ACC_W   (ACC_W),
    .PHASE_W (PHASE_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op_sel      (op_sel),
    .next        (next),
    .restart     (restart),
    .block       (block),
    .fnum        (fnum),
    .mult        (mult),
    .vib         (vib),
    .dvb         (dvb),
    .sync_en     (sync_en),
    .pm_offset   (pm_offset),
    .ready       (ready),
    .phase       (phase),
    .phase_valid (phase_valid),
    .wrap        (wrap),
    .noise       (noise)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int op, input logic [2:0] blk, input logic [9:0] fn,
                      input logic [3:0] ml, input logic rs, input logic sy,
                      input logic [PHASE_W-1:0] pm);
    op_sel = 6'(op); block = blk; fnum = fn; mult = ml;
    restart = rs; sync_en = sy; pm_offset = pm; next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
  endtask

  task automatic frame_steps(input int n, input bit chk_noise);
    for (int i = 0; i < n; i++) begin
      step(NUM_OPS - 1, 3'd0, 10'h001, 4'd0, 1'b0, 1'b0, '0);
      lfsr_m = {lfsr_m[21:0], lfsr_m[22] ^ lfsr_m[17]};
      if (chk_noise) check("noise_step", noise, lfsr_m[22]);
    end
  endtask

  task automatic reset_and_wait(input logic poke);
    int cnt;
    int pulses;
    reset = 1'b1; next = 1'b0; restart = 1'b0; sync_en = 1'b0;
    pm_offset = '0; op_sel = '0; fnum = 10'h200; block = '0; mult = 4'd1;
    @(posedge clk); #1;
    check("rst_ready", ready, 0);
    check("rst_phase", phase, 0);
    check("rst_valid", phase_valid, 0);
    check("rst_wrap",  wrap, 0);
    check("rst_noise", noise, 0);
    lfsr_m = 23'd1;
    reset = 1'b0;
    next = poke;
    cnt = 0;
    pulses = 0;
    while (!ready && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (phase_valid) pulses++;
      if (cnt == 20) next = 1'b0;
    end
    next = 1'b0;
    check("ready_latency", cnt, NUM_OPS + 1);
    check("clear_no_pulse", pulses, 0);
  endtask

  initial begin
    vib = 1'b0; dvb = 1'b0;
    reset_and_wait(1'b1);
    check("ready_high", ready, 1);

    // Four back-to-back steps on slot 0: inc 256 each.
    for (int i = 0; i < 4; i++) begin
      step(0, 3'd0, 10'h200, 4'd1, 1'b0, 1'b0, '0);
      check("seq_valid", phase_valid, 1);
      check("seq_phase", phase, exp_seq[i]);
    end
    @(posedge clk); #1;
    check("idle_valid", phase_valid, 0);
    check("idle_hold",  phase, 2);
    step(0, 3'd0, 10'h200, 4'd1, 1'b0, 1'b0, 10'h3FF);
    check("pm_offset", phase, 1);

    // Slot 3 primed non-zero, slot 2 driven to 0x7FF00 then wrapped.
    step(3, 3'd7, 10'h3FF, 4'd15, 1'b1, 1'b0, '0);
    check("prime3_phase", phase, 10'h3BE);
    step(2, 3'd7, 10'h3FF, 4'd15, 1'b1, 1'b0, '0);
    check("s2_restart", phase, 10'h3BE);
    step(2, 3'd6, 10'h20B, 4'd2, 1'b0, 1'b0, '0);
    check("s2_top_phase", phase, 10'h3FF);
    check("s2_top_wrap",  wrap, 0);
    step(2, 3'd1, 10'h200, 4'd1, 1'b0, 1'b0, '0);
    check("s2_wrap_phase", phase, 0);
    check("s2_wrap",       wrap, 1);
    step(3, 3'd6, 10'h20B, 4'd2, 1'b0, 1'b1, '0);
    check("sync_phase", phase, 10'h041);
    check("sync_wrap",  wrap, 0);
    step(3, 3'd6, 10'h20B, 4'd2, 1'b0, 1'b1, '0);
    check("nosync_phase", phase, 10'h082);

    // Leave wrap set and phase non-zero, then reset mid-run.
    step(4, 3'd7, 10'h3FF, 4'd15, 1'b1, 1'b0, '0);
    step(4, 3'd7, 10'h3FF, 4'd15, 1'b0, 1'b0, '0);
    check("pre_rst_wrap",  wrap, 1);
    check("pre_rst_phase", phase, 10'h37C);
    reset_and_wait(1'b0);

    for (int s = 0; s < 4; s++) begin
      step(s, 3'd1, 10'h200, 4'd1, 1'b0, 1'b0, '0);
      check("cleared_slot", phase, 1);
      check("cleared_wrap", wrap, 0);
    end

    frame_steps(36, 1'b1);
    check("vcnt_36", dut.vcnt_q, 36);
    step(40, 3'd0, 10'h200, 4'd1, 1'b1, 1'b0, 10'h155);
    check("oob_valid", phase_valid, 0);
    check("oob_phase", phase, 0);
    check("oob_vcnt",  dut.vcnt_q, 36);
    check("oob_noise", noise, lfsr_m[22]);

    // Vibrato: vcnt=3072 -> +1 (dvb=0, halved twice, not inverted).
    frame_steps(3072 - 36, 1'b0);
    check("vcnt_3072", dut.vcnt_q, 3072);
    check("noise_3072", noise, lfsr_m[22]);
    vib = 1'b1; dvb = 1'b0;
    step(1, 3'd0, 10'h3FF, 4'd1, 1'b1, 1'b0, '0);
    check("vib_p1_phase", phase, 1);
    check("vib_p1_wrap",  wrap, 0);
    vib = 1'b0;

    // vcnt=4096, dvb=1 -> ~7.
    frame_steps(4096 - 3072, 1'b0);
    vib = 1'b1; dvb = 1'b1;
    step(1, 3'd2, 10'h381, 4'd2, 1'b1, 1'b0, '0);
    check("vib_n7_phase", phase, 6);
    check("vib_n7_wrap",  wrap, 1);
    vib = 1'b0;

    // vcnt=7168, dvb=0 -> ~1.
    frame_steps(7168 - 4096, 1'b0);
    check("vcnt_7168", dut.vcnt_q, 7168);
    check("noise_7168", noise, lfsr_m[22]);
    vib = 1'b1; dvb = 1'b0;
    step(1, 3'd2, 10'h201, 4'd1, 1'b1, 1'b0, '0);
    check("vib_n1_phase", phase, 2);
    check("vib_n1_wrap",  wrap, 1);
    vib = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
